// File: rtl/mem_sram_bridge.sv
// rtl/mem_sram_bridge.sv - req/gnt/rvalid slave driving a 1-cycle-latency single-port block RAM with wait states.
// Optional address range checking is enabled by defining MEM_SRAM_BRIDGE_RANGE_CHECK_EN.
module mem_sram_bridge #(
  parameter int          ADDR_WIDTH  = 14,
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic [31:0]           addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  ram_en_o,
  output logic [3:0]            ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_CAPTURE,
    S_RESP
  } state_t;

  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

  state_t                  state;
  state_t                  next_state;
  logic [7:0]              cnt;
  logic                    we_q;
  logic [3:0]              be_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic                    err_q;
  logic                    flag_d;
  logic                    enter_access;
  logic                    from_idle;

  logic unused_addr;
  assign unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

`ifdef MEM_SRAM_BRIDGE_RANGE_CHECK_EN
  localparam logic [32:0] RAM_BYTES = 33'(1) << (ADDR_WIDTH + 2);
  localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_EXT = BASE_EXT + RAM_BYTES;
  assign flag_d = ({1'b0, addr_i} < BASE_EXT) || ({1'b0, addr_i} >= LIMIT_EXT);
  assign err_o  = rvalid_o && err_q;
`else
  assign flag_d = 1'b0;
  assign err_o  = 1'b0;
`endif

  always_comb begin
    next_state = state;
    gnt_o      = 1'b0;
    case (state)
      S_IDLE: begin
        gnt_o = req_i;
        if (req_i) next_state = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      end
      S_WAIT:    if (cnt == 8'd1) next_state = S_ACCESS;
      S_ACCESS:  next_state = S_CAPTURE;
      S_CAPTURE: next_state = S_RESP;
      S_RESP:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Flagged transfers still walk through ACCESS so latency is identical; only the RAM strobe is masked.
  assign ram_en_o = (state == S_ACCESS) && !err_q;
  assign ram_we_o = (ram_en_o && we_q) ? be_q : 4'h0;
  assign rvalid_o = (state == S_RESP);

  assign enter_access = (next_state == S_ACCESS) && (state != S_ACCESS);
  assign from_idle    = (state == S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      rdata_o     <= 32'h0;
      ram_addr_o  <= '0;
      ram_wdata_o <= 32'h0;
    end else begin
      state <= next_state;
      if (from_idle && req_i) begin
        cnt     <= WAIT_INIT;
        we_q    <= we_i;
        be_q    <= be_i;
        addr_q  <= addr_i[ADDR_WIDTH+1:2];
        wdata_q <= wdata_i;
        err_q   <= flag_d;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 8'd1;
      end
      // RAM address/data only move at the edge entering ACCESS; with zero wait states that edge is the grant.
      if (enter_access) begin
        ram_addr_o  <= from_idle ? addr_i[ADDR_WIDTH+1:2] : addr_q;
        ram_wdata_o <= from_idle ? wdata_i : wdata_q;
      end
      if (state == S_CAPTURE) begin
        if (err_q)     rdata_o <= 32'hDEAD_BEEF;
        else if (we_q) rdata_o <= 32'h0;
        else           rdata_o <= ram_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_sram_bridge.sv
// tb/tb_mem_sram_bridge.sv - directed self-checking bench for mem_sram_bridge with a behavioural block RAM.
module tb_mem_sram_bridge;

  logic        clk;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] mem [0:16383];

  mem_sram_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req),
    .addr_i      (addr),
    .we_i        (we),
    .be_i        (be),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .err_o       (err),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  // One full transaction: grant in cycle 0, RAM strobe in cycle 3, response in cycle 5.
  task automatic txn(input string name, input logic [31:0] a, input logic w, input logic [3:0] b,
                     input logic [31:0] d, input logic exp_en, input logic [13:0] exp_addr,
                     input logic [31:0] exp_rdata, input logic exp_err);
    logic [3:0] exp_we;
    exp_we = (exp_en && w) ? b : 4'h0;
    @(negedge clk);
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
    #1;
    total_cnt++;
    if (gnt !== 1'b1) $display("FAIL %s gnt: got %b want 1", name, gnt); else pass_cnt++;
    @(posedge clk);
    #1 req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      total_cnt++;
      if (rvalid !== (k == 5)) $display("FAIL %s rvalid c%0d: got %b want %b", name, k, rvalid, (k == 5));
      else pass_cnt++;
      if (k == 3) begin
        total_cnt++;
        if (ram_en !== exp_en) $display("FAIL %s ram_en: got %b want %b", name, ram_en, exp_en); else pass_cnt++;
        total_cnt++;
        if (ram_we !== exp_we) $display("FAIL %s ram_we: got %h want %h", name, ram_we, exp_we); else pass_cnt++;
        if (exp_en) begin
          total_cnt++;
          if (ram_addr !== exp_addr) $display("FAIL %s ram_addr: got %h want %h", name, ram_addr, exp_addr);
          else pass_cnt++;
          total_cnt++;
          if (ram_wdata !== d) $display("FAIL %s ram_wdata: got %h want %h", name, ram_wdata, d); else pass_cnt++;
        end
      end else begin
        total_cnt++;
        if (ram_en !== 1'b0) $display("FAIL %s ram_en c%0d: got %b want 0", name, k, ram_en); else pass_cnt++;
      end
      if (k == 5 || k == 6) begin
        total_cnt++;
        if (rdata !== exp_rdata) $display("FAIL %s rdata c%0d: got %h want %h", name, k, rdata, exp_rdata);
        else pass_cnt++;
        total_cnt++;
        if (err !== (exp_err && k == 5)) $display("FAIL %s err c%0d: got %b want %b", name, k, err, (exp_err && k == 5));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset;
    int en_seen;
    reset = 1'b1; req = 1'b0; addr = 32'h0; we = 1'b0; be = 4'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({gnt, rvalid, err, ram_en} !== 4'b0000)
      $display("FAIL reset flags: got %b want 0000", {gnt, rvalid, err, ram_en});
    else pass_cnt++;
    total_cnt++;
    if (ram_we !== 4'h0) $display("FAIL reset ram_we: got %h want 0", ram_we); else pass_cnt++;
    total_cnt++;
    if ({rdata, ram_wdata} !== 64'h0) $display("FAIL reset data: got %h/%h want 0", rdata, ram_wdata); else pass_cnt++;
    total_cnt++;
    if (ram_addr !== 14'h0) $display("FAIL reset ram_addr: got %h want 0", ram_addr); else pass_cnt++;
    reset = 1'b0;
    en_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ram_en || rvalid || gnt) en_seen++;
    end
    total_cnt++;
    if (en_seen != 0) $display("FAIL idle activity: got %0d active cycles want 0", en_seen); else pass_cnt++;
  endtask

  task automatic test_write_read;
    txn("write_full", 32'h0010_0010, 1'b1, 4'hF, 32'hA5A5_1234, 1'b1, 14'd4, 32'h0, 1'b0);
    txn("read_full", 32'h0010_0010, 1'b0, 4'h0, 32'h0, 1'b1, 14'd4, 32'hA5A5_1234, 1'b0);
    txn("write_byte", 32'h0010_0010, 1'b1, 4'b0010, 32'h0000_7700, 1'b1, 14'd4, 32'h0, 1'b0);
    txn("read_byte", 32'h0010_0010, 1'b0, 4'h0, 32'h0, 1'b1, 14'd4, 32'hA5A5_7734, 1'b0);
    txn("write_be0", 32'h0010_0010, 1'b1, 4'h0, 32'hFFFF_FFFF, 1'b1, 14'd4, 32'h0, 1'b0);
    txn("read_be0", 32'h0010_0010, 1'b0, 4'h0, 32'h0, 1'b1, 14'd4, 32'hA5A5_7734, 1'b0);
    txn("write_top", 32'h0010_FFFC, 1'b1, 4'hF, 32'h0BAD_F00D, 1'b1, 14'h3FFF, 32'h0, 1'b0);
    txn("read_top", 32'h0010_FFFC, 1'b0, 4'h0, 32'h0, 1'b1, 14'h3FFF, 32'h0BAD_F00D, 1'b0);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    req = 1'b1; addr = 32'h0010_0010; we = 1'b0; be = 4'h0; wdata = 32'h0;
    #1;
    total_cnt++;
    if (gnt !== 1'b1) $display("FAIL b2b first gnt: got %b want 1", gnt); else pass_cnt++;
    @(posedge clk);
    #1 addr = 32'h0010_0020; we = 1'b1; be = 4'hF; wdata = 32'h1111_2222;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 7) req = 1'b0;
      total_cnt++;
      if (gnt !== (k == 6)) $display("FAIL b2b gnt c%0d: got %b want %b", k, gnt, (k == 6)); else pass_cnt++;
      total_cnt++;
      if (rvalid !== (k == 5 || k == 11))
        $display("FAIL b2b rvalid c%0d: got %b want %b", k, rvalid, (k == 5 || k == 11));
      else pass_cnt++;
      if (k == 5) begin
        total_cnt++;
        if (rdata !== 32'hA5A5_7734) $display("FAIL b2b rdata1: got %h want a5a57734", rdata); else pass_cnt++;
      end
      if (k == 11) begin
        total_cnt++;
        if (rdata !== 32'h0) $display("FAIL b2b rdata2: got %h want 0", rdata); else pass_cnt++;
      end
    end
    txn("b2b_readback", 32'h0010_0020, 1'b0, 4'h0, 32'h0, 1'b1, 14'd8, 32'h1111_2222, 1'b0);
  endtask

  task automatic test_reset_midflight;
    int act;
    @(negedge clk);
    req = 1'b1; addr = 32'h0010_0020; we = 1'b1; be = 4'hF; wdata = 32'hCAFE_0001;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    act = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rvalid || ram_en) act++;
    end
    total_cnt++;
    if (act != 0) $display("FAIL reset_wait activity: got %0d want 0", act); else pass_cnt++;
    txn("after_reset_read", 32'h0010_0020, 1'b0, 4'h0, 32'h0, 1'b1, 14'd8, 32'h1111_2222, 1'b0);
    @(negedge clk);
    req = 1'b1; addr = 32'h0010_0020; we = 1'b1; be = 4'hF; wdata = 32'hCAFE_0002;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (ram_en !== 1'b1) $display("FAIL reset_access pre: got %b want 1", ram_en); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (ram_en !== 1'b0 || ram_we !== 4'h0)
      $display("FAIL reset_access async drop: got %b/%h want 0/0", ram_en, ram_we);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    act = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rvalid) act++;
    end
    total_cnt++;
    if (act != 0) $display("FAIL reset_access response: got %0d want 0", act); else pass_cnt++;
    txn("after_reset_read2", 32'h0010_0020, 1'b0, 4'h0, 32'h0, 1'b1, 14'd8, 32'h1111_2222, 1'b0);
  endtask

  task automatic test_range;
`ifdef MEM_SRAM_BRIDGE_RANGE_CHECK_EN
    txn("range_low", 32'h0000_0000, 1'b0, 4'h0, 32'h0, 1'b0, 14'd0, 32'hDEAD_BEEF, 1'b1);
    txn("range_high", 32'h0011_0000, 1'b1, 4'hF, 32'h1234_5678, 1'b0, 14'd0, 32'hDEAD_BEEF, 1'b1);
    txn("range_ok", 32'h0010_0010, 1'b0, 4'h0, 32'h0, 1'b1, 14'd4, 32'hA5A5_7734, 1'b0);
`else
    txn("alias_read", 32'h0000_0010, 1'b0, 4'h0, 32'h0, 1'b1, 14'd4, 32'hA5A5_7734, 1'b0);
    txn("alias_high", 32'hFFFF_0020, 1'b0, 4'h0, 32'h0, 1'b1, 14'd8, 32'h1111_2222, 1'b0);
`endif
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_back_to_back;
    test_reset_midflight;
    test_range;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
